// File: rtl/sr_flag_bank.sv
// rtl/sr_flag_bank.sv - bank of N synchronous SR flags with conflict resolution and conflict counter
//
// Purpose:
//   Clocked replacement for a cross-coupled SR latch. Each of N channels holds
//   one flag. The flag is set by s, cleared by r, and resolved by MODE when
//   both are asserted. Inputs may be level- or rising-edge-sensitive (EDGE).
//   Conflict cycles are counted in a saturating counter.
//
// Parameters:
//   N      number of flag channels (1..32)
//   MODE   S=R=1 resolution: 0 set wins, 1 reset wins, 2 hold, 3 toggle
//   EDGE   0 level-sensitive s/r, 1 rising-edge-sensitive s/r
//   CNT_W  conflict counter width (>=1)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   en            update enable; 0 freezes the flags
//   s, r          per-channel set / reset requests
//   clr_cnt       synchronous clear of the conflict counter
//   q, q_n        registered flag state and its registered complement
//   any_q         registered OR of the flag state
//   conflict      registered: some channel saw effective S=R=1 in the last enabled cycle
//   conflict_cnt  saturating count of conflict cycles

module sr_flag_bank #(
    parameter int N     = 8,
    parameter int MODE  = 0,
    parameter int EDGE  = 0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             clr_cnt,
    output logic [N-1:0]     q,
    output logic [N-1:0]     q_n,
    output logic             any_q,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    generate
        if (N < 1 || N > 32 || MODE < 0 || MODE > 3 ||
            EDGE < 0 || EDGE > 1 || CNT_W < 1) begin : g_param_check
            $fatal(1, "sr_flag_bank: illegal parameter combination");
        end
    endgenerate

    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     q_n_q;
    logic             any_q_q;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     s_hist_q, r_hist_q;

    logic [N-1:0]     se, re;
    logic [N-1:0]     both;
    logic [N-1:0]     resolved;

    // Effective requests. In edge mode the history registers load every
    // non-reset cycle, independent of en, so edges seen while disabled are
    // consumed and not replayed later.
    generate
        if (EDGE == 1) begin : g_edge
            assign se = s & ~s_hist_q;
            assign re = r & ~r_hist_q;
        end else begin : g_level
            assign se = s;
            assign re = r;
        end
    endgenerate

    assign both = se & re;

    always_comb begin
        resolved = '0;
        unique case (MODE)
            0:       resolved = '1;
            1:       resolved = '0;
            2:       resolved = q_q;
            default: resolved = ~q_q;
        endcase
    end

    always_comb begin
        q_d        = q_q;
        conflict_d = 1'b0;
        cnt_d      = cnt_q;
        if (en) begin
            // Hold where idle, set/clear where exactly one request is present,
            // MODE-resolved value where both are present.
            q_d = (q_q & ~se & ~re) | (se & ~re) | (both & resolved);
            conflict_d = |both;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (conflict_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // q_n and any_q are derived from the next state, not from q_q, so they
    // change on the same edge as q and q_n is always the exact complement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q        <= '0;
            q_n_q      <= '1;
            any_q_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
            s_hist_q   <= '0;
            r_hist_q   <= '0;
        end else begin
            q_q        <= q_d;
            q_n_q      <= ~q_d;
            any_q_q    <= |q_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
            s_hist_q   <= s;
            r_hist_q   <= r;
        end
    end

    assign q            = q_q;
    assign q_n          = q_n_q;
    assign any_q        = any_q_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule
